icache_dm: RTL
==============

// Module: icache_dm
// PURPOSE
// - Parametrised direct-mapped, read-only instruction cache between datapath (imem* side) and memory arbiter (i* side).
// - Successor to the single-cycle i-side passthrough: hits return in the same cycle; misses fill a whole multi-word block.
// - Instantiated inside caches; one instance per CPU.
// PARAMETERS
// - SETS             16  number of lines; power of 2, >= 2
// - WORDS_PER_BLOCK  2   32-bit words per line; power of 2, >= 1
// - CPUID            0   carried for multicore builds; no functional effect
// PORTS
// - CLK        in   1   clock, rising edge
// - RST        in   1   reset, asynchronous, active-high
// - imemREN    in   1   datapath fetch request
// - imemaddr   in   32  fetch byte address; [1:0] ignored
// - ihit       out  1   fetch satisfied this cycle
// - imemload   out  32  instruction; valid when ihit=1
// - inval      in   1   invalidate all lines (e.g. on halt or self-modifying code)
// - iREN       out  1   memory read request
// - iaddr      out  32  memory word address, [1:0]=2'b00
// - iwait      in   1   memory busy; iload is valid in a cycle where iREN=1 and iwait=0
// - iload      in   32  memory read data
// BEHAVIOUR
// - Address split: [1:0] byte | WO=log2(WORDS_PER_BLOCK) word offset | IX=log2(SETS) index | remaining bits are the tag.
//   - If WORDS_PER_BLOCK=1, WO=0 and the word-offset field is absent.
// - Storage per line: valid bit, tag, and WORDS_PER_BLOCK data words.
//   - RST clears every valid bit asynchronously; data and tag storage are not reset.
// - Reset values: state=IDLE, ihit=0, iREN=0, iaddr=0, imemload=0, word counter=0.
// - FSM states: IDLE and FETCH.
// - IDLE:
//   - hit = imemREN & valid[ix] & (tag[ix]==addr tag).
//   - ihit=hit combinationally; imemload=data[ix][wo] (0 when not hit). Zero-latency hit.
//   - On imemREN & ~hit & ~inval: latch the miss tag and index, clear the word counter, go to FETCH.
// - FETCH:
//   - iREN=1; iaddr={latched tag, latched index, counter, 2'b00}; ihit=0.
//   - Each cycle with iwait=0: write iload to data[idx][counter] and increment the counter.
//   - When the counter reaches WORDS_PER_BLOCK-1 and iwait=0: set valid and tag for the line, go to IDLE.
//   - The refetched address hits on the next cycle (miss cost = WORDS_PER_BLOCK memory beats + 1 cycle).
//   - Fill always starts at word 0; there is no critical-word-first.
//   - Changes on imemaddr or imemREN during FETCH are ignored; the latched block always completes.
//   - A deasserted imemREN does not abort the fill.
// - inval:
//   - Synchronous; clears all valid bits at the next edge.
//   - In IDLE, ihit is forced to 0 during the inval cycle.
//   - In FETCH, the fill aborts: return to IDLE without setting valid. A beat accepted in that cycle is discarded.
//   - inval takes priority over a miss transition and over line install in the same cycle.
// - Conflict miss: a new tag at the same index overwrites the line. The old data words are replaced one per beat and valid stays 0 until the fill completes, so no partial line ever hits.
// - The address counter wraps within the block only; iaddr never carries into the index field.
// - No write port. Stores to instruction memory require inval to guarantee coherence.
// CONFIGURATION
// - Macro ICACHE_STATS_EN.
// - Defined: adds two output ports, each a 32-bit counter cleared by RST and wrapping at 2^32-1:
//   - hit_count  out 32  +1 per cycle with ihit=1.
//   - miss_count out 32  +1 per IDLE->FETCH transition.
//   - inval does not clear either counter.
// - Undefined: both ports and counters are absent; all other behaviour is identical.
// TESTING
// - Cold miss, SETS=16, WPB=2, imemaddr=0x0000_0040, iwait=0 after 2 cycles per beat:
//   - iaddr goes 0x40 then 0x44; next cycle ihit=1 with the word from 0x40.
//   - Then imemaddr=0x44 -> ihit=1 the same cycle, iREN=0.
// - Conflict: fill 0x40, then request 0x0000_00C0 (same index, new tag):
//   - Miss fills 0xC0/0xC4; a later request to 0x40 misses again.
// - Hit under sweep: fill lines at 0x00..0x7C:
//   - 32 sequential fetches give 32 hits, iREN stays 0, hit_count=32 (with ICACHE_STATS_EN).
// - inval mid-fill: miss on 0x100, assert inval after the first beat:
//   - FSM returns to IDLE, iREN=0 next cycle.
//   - Re-request 0x100 misses and refetches from 0x100.
// - Async reset: assert RST mid-FETCH off-edge:
//   - iREN and ihit drop immediately; all lines invalid; the first fetch after release misses.
// - imemREN dropped and imemaddr changed during a fill of 0x200:
//   - Fill completes for 0x200/0x204, the line becomes valid, miss_count=1.

Source files
------------

// File: rtl/icache_dm_if.sv
// Datapath fetch port and memory-arbiter read port of the direct-mapped I-cache.
// Latency: none (wires only).
// Backpressure: the memory side stalls the fill through iwait.
//
// Port summary
//   imemREN / imemaddr / ihit / imemload : datapath fetch request and response
//   inval                                : invalidate every line
//   iREN / iaddr / iwait / iload         : memory read request, stall and data
//
// Modports
//   slave  : the cache
//   master : the datapath and memory arbiter that surround it
interface icache_dm_if;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        inval;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;

  modport slave (
    input  imemREN, imemaddr, inval, iwait, iload,
    output ihit, imemload, iREN, iaddr
  );

  modport master (
    output imemREN, imemaddr, inval, iwait, iload,
    input  ihit, imemload, iREN, iaddr
  );
endinterface

// File: rtl/icache_dm.sv
// Direct-mapped, read-only instruction cache between the datapath and the memory arbiter.
// Latency: a hit answers in the same cycle; a miss costs WORDS_PER_BLOCK memory beats plus one cycle.
// Backpressure: iwait stalls the fill one beat at a time; the datapath sees ihit=0 until the line is installed.
//
// Ports
//   CLK, RST  : clock (rising edge) and asynchronous active-high reset
//   cif       : icache_dm_if.slave (fetch port, inval, memory read port)
//   hit_count : cycles with ihit=1      (only when ICACHE_STATS_EN is defined)
//   miss_count: IDLE->FETCH transitions (only when ICACHE_STATS_EN is defined)
//
// Optional build macro: ICACHE_STATS_EN adds the two wrapping 32-bit statistics counters.
module icache_dm #(
  parameter int SETS            = 16,
  parameter int WORDS_PER_BLOCK = 2,
  parameter int CPUID           = 0
) (
  input  logic        CLK,
  input  logic        RST,
`ifdef ICACHE_STATS_EN
  icache_dm_if.slave  cif,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`else
  icache_dm_if.slave  cif
`endif
);

  localparam int WO = $clog2(WORDS_PER_BLOCK);
  localparam int IX = $clog2(SETS);
  localparam int TW = 30 - WO - IX;
  // Counter keeps at least one bit so single-word blocks still elaborate.
  localparam int CW = (WO > 0) ? WO : 1;
  localparam logic [CW-1:0] LAST_WORD = CW'(WORDS_PER_BLOCK - 1);
  // CPUID only tags the instance in multicore builds.
  localparam int UNUSED_CPUID = CPUID;

  typedef enum logic {IDLE, FETCH} state_t;

  state_t state, state_d;

  // Line storage; only the valid bits are reset.
  logic [SETS-1:0] valid;
  logic [TW-1:0]   tags [SETS];
  logic [31:0]     data [SETS][WORDS_PER_BLOCK];

  // Fill bookkeeping.
  logic [TW-1:0] miss_tag;
  logic [IX-1:0] miss_ix;
  logic [CW-1:0] cnt;
  logic [31:0]   fill_addr;

  // Fetch address fields.
  logic [IX-1:0] ix;
  logic [TW-1:0] tg;
  logic [CW-1:0] wo;
  logic          hit_raw;

  // Decoded actions for this cycle.
  logic start_fill;
  logic beat;
  logic done;

  logic unused_addr_bits;
  assign unused_addr_bits = ^cif.imemaddr[1:0];

  assign ix = cif.imemaddr[2+WO +: IX];
  assign tg = cif.imemaddr[31 -: TW];

  generate
    if (WO > 0) begin : g_multi_word
      assign wo        = cif.imemaddr[2 +: CW];
      assign fill_addr = {miss_tag, miss_ix, cnt, 2'b00};
    end else begin : g_single_word
      assign wo        = '0;
      assign fill_addr = {miss_tag, miss_ix, 2'b00};
    end
  endgenerate

  assign hit_raw = cif.imemREN & valid[ix] & (tags[ix] == tg);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d      = state;
    cif.ihit     = 1'b0;
    cif.imemload = '0;
    cif.iREN     = 1'b0;
    cif.iaddr    = '0;
    start_fill   = 1'b0;
    beat         = 1'b0;
    done         = 1'b0;
    case (state)
      IDLE: begin
        // inval masks both the hit and a new miss in the same cycle.
        if (!cif.inval) begin
          cif.ihit = hit_raw;
          if (hit_raw) cif.imemload = data[ix][wo];
          if (cif.imemREN && !hit_raw) begin
            start_fill = 1'b1;
            state_d    = FETCH;
          end
        end
      end
      FETCH: begin
        cif.iREN  = 1'b1;
        cif.iaddr = fill_addr;
        if (cif.inval) begin
          // Abort: drop any beat arriving now and leave the line invalid.
          state_d = IDLE;
        end else if (!cif.iwait) begin
          beat = 1'b1;
          if (cnt == LAST_WORD) begin
            done    = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      miss_tag <= '0;
      miss_ix  <= '0;
      cnt      <= '0;
    end else if (start_fill) begin
      miss_tag <= tg;
      miss_ix  <= ix;
      cnt      <= '0;
    end else if (beat) begin
      // Wraps inside the block, so iaddr never carries into the index.
      cnt <= (WO > 0) ? cnt + 1'b1 : '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (beat) data[miss_ix][cnt] <= cif.iload;
    if (done) tags[miss_ix]      <= miss_tag;
  end

  // The victim line is dropped as soon as its refill starts, so a partially
  // overwritten line can never hit.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)             valid          <= '0;
    else if (cif.inval)  valid          <= '0;
    else if (start_fill) valid[ix]      <= 1'b0;
    else if (done)       valid[miss_ix] <= 1'b1;
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      hit_count  <= hit_count + 32'(cif.ihit);
      miss_count <= miss_count + 32'(start_fill);
    end
  end
`endif

endmodule
